// File: rtl/cmd_pkg.sv
// Shared opcode map, response codes, FSM state type and timer limits for cmd_dispatch.
// Timer limits switch between short simulation values and full silicon values.
package cmd_pkg;

    localparam logic [7:0] OP_AXIS0     = 8'h02;
    localparam logic [7:0] OP_AXIS1     = 8'h03;
    localparam logic [7:0] OP_AXIS2     = 8'h04;
    localparam logic [7:0] OP_THRST     = 8'h05;
    localparam logic [7:0] OP_CAL       = 8'h06;
    localparam logic [7:0] OP_LAND      = 8'h07;
    localparam logic [7:0] OP_OFF       = 8'h08;
    localparam logic [7:0] OP_PING      = 8'h09;
    localparam logic [7:0] OP_AXIS_BASE = 8'h20;

    localparam logic [7:0] RESP_ACK = 8'hA5;
    localparam logic [7:0] RESP_NAK = 8'h5A;

    localparam int TMR_W = 28;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SPINUP,
        ST_CAL_WAIT,
        ST_RESP
    } state_t;

    function automatic logic [TMR_W-1:0] spinup_limit(input bit fast_sim);
        return fast_sim ? TMR_W'(511) : TMR_W'((1 << 26) - 1);
    endfunction

    function automatic logic [TMR_W-1:0] cal_limit(input bit fast_sim);
        return fast_sim ? TMR_W'(1023) : TMR_W'((1 << 27) - 1);
    endfunction

    function automatic logic [TMR_W-1:0] wdog_limit(input bit fast_sim);
        return fast_sim ? TMR_W'(4095) : TMR_W'((1 << 28) - 1);
    endfunction

    function automatic int land_div_cycles(input bit fast_sim, input int land_div);
        return fast_sim ? land_div : (1 << land_div);
    endfunction

endpackage

// File: rtl/cmd_dispatch_if.sv
// Command/response handshake between the UART command path (master) and the dispatcher (slave).
interface cmd_dispatch_if #(
    parameter int DATA_W = 16
);
    logic              cmd_rdy;
    logic [7:0]        cmd;
    logic [DATA_W-1:0] data;
    logic              clr_cmd_rdy;
    logic [7:0]        resp;
    logic              send_resp;

    modport master (
        output cmd_rdy, cmd, data,
        input  clr_cmd_rdy, resp, send_resp
    );

    modport slave (
        input  cmd_rdy, cmd, data,
        output clr_cmd_rdy, resp, send_resp
    );
endinterface

// File: rtl/land_ramp.sv
// Thrust register with a prescaled, saturating ramp-down used for emergency landing.
// done is high in the cycle where landing is active with thrust already at zero.
module land_ramp
    import cmd_pkg::*;
#(
    parameter bit FAST_SIM = 1'b1,
    parameter int THRST_W  = 9,
    parameter int LAND_DIV = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [THRST_W-1:0] load_val,
    input  logic               start,
    input  logic               abort,
    output logic [THRST_W-1:0] thrst,
    output logic               landing,
    output logic               done
);
    localparam int DIV_N = land_div_cycles(FAST_SIM, LAND_DIV);
    localparam int DIV_W = (DIV_N > 1) ? $clog2(DIV_N) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV_N - 1);

    logic [THRST_W-1:0] thrst_reg;
    logic               landing_reg;
    logic [DIV_W-1:0]   div_reg;

    // abort beats a same-cycle decrement; zero thrust ends the ramp
    always_ff @(posedge clk) begin
        if (rst) begin
            thrst_reg   <= '0;
            landing_reg <= 1'b0;
            div_reg     <= '0;
        end else if (abort) begin
            thrst_reg   <= '0;
            landing_reg <= 1'b0;
            div_reg     <= '0;
        end else if (start) begin
            landing_reg <= 1'b1;
            div_reg     <= '0;
        end else if (load) begin
            thrst_reg <= load_val;
        end else if (landing_reg) begin
            if (thrst_reg == '0) begin
                landing_reg <= 1'b0;
            end else if (div_reg == DIV_LAST) begin
                div_reg   <= '0;
                thrst_reg <= thrst_reg - 1'b1;
            end else begin
                div_reg <= div_reg + 1'b1;
            end
        end
    end

    assign thrst   = thrst_reg;
    assign landing = landing_reg;
    assign done    = landing_reg && (thrst_reg == '0);
endmodule

// File: rtl/cmd_dispatch.sv
// Remote command interpreter: decodes opcodes into setpoints/thrust, sequences spin-up and
// inertial calibration, and adds calibration timeout, link-loss watchdog and emergency landing.
module cmd_dispatch
    import cmd_pkg::*;
#(
    parameter bit FAST_SIM = 1'b1,
    parameter int NUM_AXES = 3,
    parameter int DATA_W   = 16,
    parameter int THRST_W  = 9,
    parameter int LAND_DIV = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    cmd_dispatch_if.slave              bus,
    input  logic                       cal_done,
    output logic [NUM_AXES*DATA_W-1:0] d_axis,
    output logic [THRST_W-1:0]         thrst,
    output logic                       strt_cal,
    output logic                       inertial_cal,
    output logic                       motors_off,
    output logic                       landing
);
    localparam int AX_W = (NUM_AXES > 1) ? $clog2(NUM_AXES) : 1;
    localparam logic [TMR_W-1:0] SPIN_LIM = spinup_limit(FAST_SIM);
    localparam logic [TMR_W-1:0] CAL_LIM  = cal_limit(FAST_SIM);
    localparam logic [TMR_W-1:0] WDOG_LIM = wdog_limit(FAST_SIM);

    state_t           state_reg;
    logic [7:0]       resp_reg;
    logic             send_resp_reg;
    logic             strt_cal_reg;
    logic             inertial_cal_reg;
    logic             motors_off_reg;
    logic [TMR_W-1:0] phase_reg;
    logic [TMR_W-1:0] wdog_reg;

    logic             axis_hit;
    logic [AX_W-1:0]  axis_idx;
    logic             is_thrst, is_cal, is_land, is_off, is_ping, op_valid;
    logic             idle_take, cmd_take;
    logic [7:0]       idle_resp;
    logic             land_load, land_start, land_abort, land_done, wdog_fire;
    logic             landing_int;

    // aliases 0x02..0x04 and 0x20+i only exist for axes that are actually built
    always_comb begin
        axis_hit = 1'b0;
        axis_idx = '0;
        if (bus.cmd == OP_AXIS0) begin
            axis_hit = 1'b1;
        end else if (bus.cmd == OP_AXIS1 && NUM_AXES >= 2) begin
            axis_hit = 1'b1;
            axis_idx = AX_W'(1);
        end else if (bus.cmd == OP_AXIS2 && NUM_AXES >= 3) begin
            axis_hit = 1'b1;
            axis_idx = AX_W'(2);
        end else if (bus.cmd[7:4] == OP_AXIS_BASE[7:4] && int'(bus.cmd[3:0]) < NUM_AXES) begin
            axis_hit = 1'b1;
            axis_idx = AX_W'(bus.cmd[3:0]);
        end
    end

    assign is_thrst = (bus.cmd == OP_THRST);
    assign is_cal   = (bus.cmd == OP_CAL);
    assign is_land  = (bus.cmd == OP_LAND);
    assign is_off   = (bus.cmd == OP_OFF);
    assign is_ping  = (bus.cmd == OP_PING);
    assign op_valid = axis_hit | is_thrst | is_cal | is_land | is_off | is_ping;

    // during spin-up/calibration only the motors-off opcode is consumed
    assign idle_take = bus.cmd_rdy && (state_reg == ST_IDLE);
    assign cmd_take  = idle_take || (bus.cmd_rdy && is_off &&
                       (state_reg == ST_SPINUP || state_reg == ST_CAL_WAIT));
    assign bus.clr_cmd_rdy = cmd_take;

    assign idle_resp  = (!op_valid || ((is_thrst || is_cal) && landing_int)) ? RESP_NAK : RESP_ACK;
    assign wdog_fire  = (wdog_reg == WDOG_LIM) && !motors_off_reg && !landing_int && !cmd_take;
    assign land_load  = idle_take && is_thrst && !landing_int;
    assign land_start = (idle_take && is_land) || wdog_fire;
    assign land_abort = cmd_take && is_off;

    land_ramp #(
        .FAST_SIM (FAST_SIM),
        .THRST_W  (THRST_W),
        .LAND_DIV (LAND_DIV)
    ) u_land_ramp (
        .clk      (clk),
        .rst      (rst),
        .load     (land_load),
        .load_val (bus.data[THRST_W-1:0]),
        .start    (land_start),
        .abort    (land_abort),
        .thrst    (thrst),
        .landing  (landing_int),
        .done     (land_done)
    );

    genvar gi;
    generate
        for (gi = 0; gi < NUM_AXES; gi++) begin : g_axis
            logic [DATA_W-1:0] axis_reg;
            always_ff @(posedge clk) begin
                if (rst || land_start) begin
                    axis_reg <= '0;
                end else if (idle_take && axis_hit && axis_idx == AX_W'(gi)) begin
                    axis_reg <= bus.data;
                end
            end
            assign d_axis[gi*DATA_W +: DATA_W] = axis_reg;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg        <= ST_IDLE;
            resp_reg         <= RESP_ACK;
            send_resp_reg    <= 1'b0;
            strt_cal_reg     <= 1'b0;
            inertial_cal_reg <= 1'b0;
            motors_off_reg   <= 1'b1;
            phase_reg        <= '0;
            wdog_reg         <= '0;
        end else begin
            send_resp_reg <= 1'b0;
            strt_cal_reg  <= 1'b0;
            if (land_done) motors_off_reg <= 1'b1;

            if (cmd_take || motors_off_reg) wdog_reg <= '0;
            else if (wdog_reg != WDOG_LIM) wdog_reg <= wdog_reg + 1'b1;

            case (state_reg)
                ST_IDLE: begin
                    if (idle_take) begin
                        // a granted calibrate answers only once calibration ends
                        if (is_cal && !landing_int) begin
                            state_reg        <= ST_SPINUP;
                            inertial_cal_reg <= 1'b1;
                            motors_off_reg   <= 1'b0;
                            phase_reg        <= '0;
                        end else begin
                            state_reg     <= ST_RESP;
                            resp_reg      <= idle_resp;
                            send_resp_reg <= 1'b1;
                            if (is_off) motors_off_reg <= 1'b1;
                        end
                    end
                end
                ST_SPINUP, ST_CAL_WAIT: begin
                    if (cmd_take) begin
                        state_reg        <= ST_RESP;
                        resp_reg         <= RESP_ACK;
                        send_resp_reg    <= 1'b1;
                        motors_off_reg   <= 1'b1;
                        inertial_cal_reg <= 1'b0;
                    end else if (state_reg == ST_SPINUP) begin
                        if (phase_reg == SPIN_LIM) begin
                            state_reg    <= ST_CAL_WAIT;
                            strt_cal_reg <= 1'b1;
                            phase_reg    <= '0;
                        end else begin
                            phase_reg <= phase_reg + 1'b1;
                        end
                    end else if (cal_done) begin
                        state_reg        <= ST_RESP;
                        resp_reg         <= RESP_ACK;
                        send_resp_reg    <= 1'b1;
                        inertial_cal_reg <= 1'b0;
                    end else if (phase_reg == CAL_LIM) begin
                        state_reg        <= ST_RESP;
                        resp_reg         <= RESP_NAK;
                        send_resp_reg    <= 1'b1;
                        inertial_cal_reg <= 1'b0;
                        motors_off_reg   <= 1'b1;
                    end else begin
                        phase_reg <= phase_reg + 1'b1;
                    end
                end
                ST_RESP: state_reg <= ST_IDLE;
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign bus.resp      = resp_reg;
    assign bus.send_resp = send_resp_reg;
    assign strt_cal      = strt_cal_reg;
    assign inertial_cal  = inertial_cal_reg;
    assign motors_off    = motors_off_reg;
    assign landing       = landing_int;
endmodule

// File: tb/tb_cmd_dispatch.sv
// Directed bench for cmd_dispatch: responses checked by a queue-based monitor,
// register/timing effects checked inline against hand-computed values.
module tb_cmd_dispatch;
    localparam logic [7:0] ACK = 8'hA5;
    localparam logic [7:0] NAK = 8'h5A;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cal_done = 1'b0;
    logic [63:0] d_axis;
    logic [8:0]  thrst;
    logic        strt_cal, inertial_cal, motors_off, landing;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int n_resp = 0;
    int last_acc = 0;
    logic [7:0] exp_q[$];

    cmd_dispatch_if #(.DATA_W(16)) bus();

    cmd_dispatch #(
        .FAST_SIM (1'b1),
        .NUM_AXES (4),
        .DATA_W   (16),
        .THRST_W  (9),
        .LAND_DIV (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .cal_done     (cal_done),
        .d_axis       (d_axis),
        .thrst        (thrst),
        .strt_cal     (strt_cal),
        .inertial_cal (inertial_cal),
        .motors_off   (motors_off),
        .landing      (landing)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // response monitor / scoreboard
    initial forever begin
        @(negedge clk);
        if (bus.send_resp === 1'b1) begin
            n_resp++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_resp: got 0x%02h expected none", bus.resp);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                $display("resp @%0d: 0x%02h (want 0x%02h)", cyc, bus.resp, e);
                if (bus.resp !== e) begin
                    errors++;
                    $display("FAIL resp_code: got 0x%02h expected 0x%02h", bus.resp, e);
                end
            end
        end
    end

    task automatic send(input logic [7:0] op, input logic [15:0] dat);
        @(negedge clk);
        bus.cmd_rdy = 1'b1;
        bus.cmd     = op;
        bus.data    = dat;
        #1;
        chk("clr_cmd_rdy", 64'(bus.clr_cmd_rdy), 1);
        @(posedge clk);
        #1;
        last_acc    = cyc;
        bus.cmd_rdy = 1'b0;
        @(posedge clk);
    endtask

    task automatic cal_ok();
        int acc;
        send(8'h06, 16'h0000);
        acc = last_acc;
        @(negedge clk);
        chk("cal_motors_on", 64'(motors_off), 0);
        chk("cal_inertial_hi", 64'(inertial_cal), 1);
        do @(negedge clk); while (strt_cal !== 1'b1 && cyc < acc + 700);
        chk("strt_cal_latency", 64'(cyc - acc), 512);
        @(negedge clk);
        chk("strt_cal_one_cycle", 64'(strt_cal), 0);
        exp_q.push_back(ACK);
        cal_done = 1'b1;
        @(negedge clk);
        cal_done = 1'b0;
        chk("inertial_cal_after_done", 64'(inertial_cal), 0);
        chk("motors_on_after_cal", 64'(motors_off), 0);
    endtask

    initial begin
        #(4_000_000);
        $display("FAIL global_timeout: got stuck expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int acc;
        int snap;
        bus.cmd_rdy = 1'b0;
        bus.cmd     = 8'h00;
        bus.data    = 16'h0000;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_d_axis", d_axis, 0);
        chk("rst_thrst", 64'(thrst), 0);
        chk("rst_motors_off", 64'(motors_off), 1);
        chk("rst_landing", 64'(landing), 0);
        chk("rst_resp", 64'(bus.resp), 64'hA5);
        chk("rst_strobes", 64'({bus.send_resp, strt_cal, inertial_cal}), 0);
        rst = 1'b0;

        // setpoints and thrust
        exp_q.push_back(ACK); send(8'h02, 16'h1234);
        exp_q.push_back(ACK); send(8'h23, 16'hFFF0);
        exp_q.push_back(ACK); send(8'h05, 16'h01FF);
        @(negedge clk);
        chk("axes_written", d_axis, 64'hFFF0_0000_0000_1234);
        chk("thrst_written", 64'(thrst), 64'h1FF);

        // unknown opcodes
        exp_q.push_back(NAK); send(8'h24, 16'h5555);
        exp_q.push_back(NAK); send(8'h7F, 16'h1111);
        @(negedge clk);
        chk("nak_axes_unchanged", d_axis, 64'hFFF0_0000_0000_1234);
        chk("nak_thrst_unchanged", 64'(thrst), 64'h1FF);
        chk("nak_motors_off", 64'(motors_off), 1);
        chk("resp_holds", 64'(bus.resp), 64'h5A);
        exp_q.push_back(ACK); send(8'h09, 16'h0000);

        // calibration success, then emergency land from thrust 10
        cal_ok();
        exp_q.push_back(ACK); send(8'h05, 16'd10);
        @(negedge clk);
        chk("thrst_10", 64'(thrst), 10);
        exp_q.push_back(ACK); send(8'h07, 16'h0000);
        acc = last_acc;
        @(negedge clk);
        chk("land_axes_zero", d_axis, 0);
        chk("land_active", 64'(landing), 1);
        exp_q.push_back(NAK); send(8'h05, 16'h0055);
        @(negedge clk);
        chk("thrst_ramp", 64'(thrst), 64'(10 - (cyc - acc) / 4));
        do @(negedge clk); while (thrst !== 9'd0 && cyc < acc + 100);
        chk("land_zero_latency", 64'(cyc - acc), 40);
        chk("land_still_on_at_zero", 64'(landing), 1);
        @(negedge clk);
        chk("land_cleared", 64'(landing), 0);
        chk("land_motors_off", 64'(motors_off), 1);

        // calibration timeout
        exp_q.push_back(NAK); send(8'h06, 16'h0000);
        acc = last_acc;
        do @(negedge clk); while (bus.send_resp !== 1'b1 && cyc < acc + 1700);
        chk("cal_timeout_latency", 64'(cyc - acc), 1536);
        chk("cal_timeout_motors_off", 64'(motors_off), 1);
        chk("cal_timeout_inertial", 64'(inertial_cal), 0);

        // abort during spin-up
        send(8'h06, 16'h0000);
        @(negedge clk);
        chk("abort_pre_inertial", 64'(inertial_cal), 1);
        repeat (20) @(negedge clk);
        exp_q.push_back(ACK); send(8'h08, 16'h0000);
        @(negedge clk);
        chk("abort_motors_off", 64'(motors_off), 1);
        chk("abort_inertial", 64'(inertial_cal), 0);

        // watchdog expiry with motors on
        cal_ok();
        exp_q.push_back(ACK); send(8'h05, 16'd20);
        acc = last_acc;
        snap = n_resp;
        do @(negedge clk); while (landing !== 1'b1 && cyc < acc + 4300);
        chk("wdog_latency", 64'(cyc - acc), 4096);
        chk("wdog_no_resp", 64'(n_resp), 64'(snap));
        exp_q.push_back(ACK); send(8'h08, 16'h0000);
        @(negedge clk);
        chk("off_thrst_zero", 64'(thrst), 0);
        chk("off_landing_clear", 64'(landing), 0);
        chk("off_motors_off", 64'(motors_off), 1);

        // watchdog kept alive by a ping
        cal_ok();
        exp_q.push_back(ACK); send(8'h05, 16'd20);
        acc = last_acc;
        while (cyc < acc + 3998) @(negedge clk);
        exp_q.push_back(ACK); send(8'h09, 16'h0000);
        while (cyc < acc + 4300) @(negedge clk);
        chk("ping_no_landing", 64'(landing), 0);
        chk("ping_motors_on", 64'(motors_off), 0);
        exp_q.push_back(ACK); send(8'h08, 16'h0000);

        repeat (3) @(negedge clk);
        chk("all_resps_seen", 64'(exp_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
